uxn_screen_encoder: RTL

Screen-device front end of the Varvara draw path. It decodes Uxn CPU writes to the screen device ports (0x20–0x2F), maintains the x, y, addr and auto registers, and turns each pixel or sprite port write into 24-bit draw-queue words with a write strobe. These words feed `uxn_draw_queue`'s `data`/`we` inputs. Multi-sprite (auto-length) commands expand into a sequence of queue words while `busy` stalls the CPU.

---
 rtl/uxn_screen_pkg.sv | 40 ++++
 rtl/uxn_screen_word_pack.sv | 34 +++
 rtl/uxn_screen_encoder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uxn_screen_pkg.sv
// uxn_screen_pkg: shared screen-device constants (port offsets, queue word bit positions, FSM states).
package uxn_screen_pkg;

    localparam logic [3:0] PORT_AUTO    = 4'h6;
    localparam logic [3:0] PORT_X_HI    = 4'h8;
    localparam logic [3:0] PORT_X_LO    = 4'h9;
    localparam logic [3:0] PORT_Y_HI    = 4'hA;
    localparam logic [3:0] PORT_Y_LO    = 4'hB;
    localparam logic [3:0] PORT_ADDR_HI = 4'hC;
    localparam logic [3:0] PORT_ADDR_LO = 4'hD;
    localparam logic [3:0] PORT_PIXEL   = 4'hE;
    localparam logic [3:0] PORT_SPRITE  = 4'hF;

    localparam int W0_LAYER     = 23;
    localparam int W0_COLOR_LSB = 21;
    localparam int W0_FILL      = 20;
    localparam int W0_T         = 19;
    localparam int W0_L         = 18;
    localparam int W0_X_LSB     = 9;
    localparam int W0_Y_LSB     = 0;
    localparam int COORD_W      = 9;

    localparam int W1_FY        = 19;
    localparam int W1_FX        = 18;
    localparam int W1_COLOR_LSB = 16;
    localparam int W1_ADDR_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PIX,
        ST_SPR_W0,
        ST_SPR_W1
    } state_e;

    typedef enum logic {
        MODE_PIXEL,
        MODE_SPRITE
    } mode_e;

endpackage

// File: rtl/uxn_screen_word_pack.sv
// uxn_screen_word_pack: combinational packer of a pixel/sprite command into draw-queue words.
// Ports: mode (pixel or sprite), cmd (command byte), x/y (low coordinate bits),
//        addr (sprite address) -> word0, word1. word1 is only meaningful for sprites.
module uxn_screen_word_pack
    import uxn_screen_pkg::*;
(
    input  mode_e       mode,
    input  logic [7:0]  cmd,
    input  logic [8:0]  x,
    input  logic [8:0]  y,
    input  logic [15:0] addr,
    output logic [23:0] word0,
    output logic [23:0] word1
);

    always_comb begin
        word0 = '0;
        word1 = '0;
        word0[W0_LAYER] = cmd[6];
        word0[W0_COLOR_LSB +: 2] = cmd[1:0];
        word0[W0_X_LSB +: COORD_W] = x;
        word0[W0_Y_LSB +: COORD_W] = y;
        // Pixel: fill flag in b7, t/l carry the flip bits only for fills.
        // Sprite: t is always set, l carries the 2bpp flag.
        word0[W0_FILL] = (mode == MODE_PIXEL) ? cmd[7] : 1'b0;
        word0[W0_T]    = (mode == MODE_PIXEL) ? (cmd[7] & cmd[5]) : 1'b1;
        word0[W0_L]    = (mode == MODE_PIXEL) ? (cmd[7] & cmd[4]) : cmd[7];
        word1[W1_FY] = cmd[5];
        word1[W1_FX] = cmd[4];
        word1[W1_COLOR_LSB +: 2] = cmd[3:2];
        word1[W1_ADDR_LSB +: 16] = addr;
    end

endmodule

// File: rtl/uxn_screen_encoder.sv
// uxn_screen_encoder: Varvara screen device front end; decodes port writes and emits draw-queue words.
// Ports: clk, reset_n (async active-low), dev_we/dev_port/dev_wdata (device write),
//        dev_rdata (combinational port read), busy (command expanding),
//        data/we (queue word and its one-cycle strobe).
// Option: define UXN_SCREEN_CULL_EN to suppress words for off-screen pixels/sprites.
module uxn_screen_encoder
    import uxn_screen_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dev_we,
    input  logic [3:0]  dev_port,
    input  logic [7:0]  dev_wdata,
    output logic [7:0]  dev_rdata,
    output logic        busy,
    output logic [23:0] data,
    output logic        we
);

    state_e      state, state_next;
    logic [15:0] x, y, addr;
    logic [7:0]  auto_cfg;
    logic [7:0]  cmd;
    logic [15:0] spr_x, spr_y, spr_a;
    logic [3:0]  idx;
    logic [23:0] word0, word1;
    logic        cull;

    logic [3:0]  n;
    logic [15:0] dx, dy, step;
    logic        fx, fy, last;

    assign n    = auto_cfg[7:4];
    assign dx   = auto_cfg[0] ? 16'd8 : 16'd0;
    assign dy   = auto_cfg[1] ? 16'd8 : 16'd0;
    assign step = auto_cfg[2] ? (cmd[7] ? 16'd16 : 16'd8) : 16'd0;
    assign fx   = cmd[4];
    assign fy   = cmd[5];
    assign last = (idx == n);

    // spr_x/spr_y/spr_a hold the coordinates of the item being emitted, so
    // the architectural x/y/addr only change once the whole command is done.
    uxn_screen_word_pack u_pack (
        .mode  ((state == ST_PIX) ? MODE_PIXEL : MODE_SPRITE),
        .cmd   (cmd),
        .x     (spr_x[8:0]),
        .y     (spr_y[8:0]),
        .addr  (spr_a),
        .word0 (word0),
        .word1 (word1)
    );

`ifdef UXN_SCREEN_CULL_EN
    logic off_screen;
    assign off_screen = (|spr_x[15:9]) | (|spr_y[15:9]);
    assign cull = off_screen & ~((state == ST_PIX) & cmd[7]);
`else
    assign cull = 1'b0;
`endif

    always_comb begin
        state_next = state;
        we = 1'b0;
        data = '0;
        case (state)
            ST_IDLE: begin
                if (dev_we && dev_port == PORT_PIXEL) state_next = ST_PIX;
                if (dev_we && dev_port == PORT_SPRITE) state_next = ST_SPR_W0;
            end
            ST_PIX: begin
                we = ~cull;
                data = word0;
                state_next = ST_IDLE;
            end
            ST_SPR_W0: begin
                we = ~cull;
                data = word0;
                state_next = ST_SPR_W1;
            end
            ST_SPR_W1: begin
                we = ~cull;
                data = word1;
                state_next = last ? ST_IDLE : ST_SPR_W0;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            x        <= '0;
            y        <= '0;
            addr     <= '0;
            auto_cfg <= '0;
            cmd      <= '0;
            spr_x    <= '0;
            spr_y    <= '0;
            spr_a    <= '0;
            idx      <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (dev_we) begin
                        case (dev_port)
                            PORT_AUTO:    auto_cfg   <= dev_wdata;
                            PORT_X_HI:    x[15:8]    <= dev_wdata;
                            PORT_X_LO:    x[7:0]     <= dev_wdata;
                            PORT_Y_HI:    y[15:8]    <= dev_wdata;
                            PORT_Y_LO:    y[7:0]     <= dev_wdata;
                            PORT_ADDR_HI: addr[15:8] <= dev_wdata;
                            PORT_ADDR_LO: addr[7:0]  <= dev_wdata;
                            PORT_PIXEL, PORT_SPRITE: begin
                                cmd   <= dev_wdata;
                                spr_x <= x;
                                spr_y <= y;
                                spr_a <= addr;
                                idx   <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_PIX: begin
                    if (auto_cfg[0]) x <= x + 16'd1;
                    if (auto_cfg[1]) y <= y + 16'd1;
                end
                ST_SPR_W1: begin
                    if (last) begin
                        x    <= fx ? x - dx : x + dx;
                        y    <= fy ? y - dy : y + dy;
                        addr <= spr_a + step;
                    end else begin
                        // Successive sprites step x by dy and y by dx.
                        spr_x <= fx ? spr_x - dy : spr_x + dy;
                        spr_y <= fy ? spr_y - dx : spr_y + dx;
                        spr_a <= spr_a + step;
                        idx   <= idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (dev_port)
            PORT_AUTO:    dev_rdata = auto_cfg;
            PORT_X_HI:    dev_rdata = x[15:8];
            PORT_X_LO:    dev_rdata = x[7:0];
            PORT_Y_HI:    dev_rdata = y[15:8];
            PORT_Y_LO:    dev_rdata = y[7:0];
            PORT_ADDR_HI: dev_rdata = addr[15:8];
            PORT_ADDR_LO: dev_rdata = addr[7:0];
            default:      dev_rdata = 8'h00;
        endcase
    end

endmodule
